timer_ctrl: RTL and testbench

APB-programmable controller for the 32-bit timer. It holds the timer configuration and counter registers, generates prescaled count ticks, and sequences load, count-up and count-down. It detects overflow and underflow, keeps sticky status with write-1-to-clear, and drives a single level interrupt to the interrupt handler. It sits between the APB bus and the CPU interrupt input, replacing direct wiring of load/en/updown/trig_clr.

---
 rtl/timer_ctrl_if.sv | 22 ++
 rtl/timer_ctrl.sv | 123 ++++++++++++
 tb/tb_timer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// APB slave-side bundle for the timer controller: select/enable/write strobes,
// address and data, plus the fixed-handshake response lines.
interface timer_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_ctrl.sv
// APB-programmable 32-bit timer controller: config/count registers, prescaled
// ticks, up/down counting with overflow/underflow sticky status and level IRQ.
module timer_ctrl (
    input  logic        i_pclk,
    input  logic        i_preset_n,
    timer_ctrl_if.slave apb,
    output logic        o_tmr_irq
);
    localparam logic [9:0] A_TCR  = 10'd0;
    localparam logic [9:0] A_TDR  = 10'd1;
    localparam logic [9:0] A_TCNT = 10'd2;
    localparam logic [9:0] A_TIER = 10'd3;
    localparam logic [9:0] A_TISR = 10'd4;

    logic        r_en;
    logic        r_updown;
    logic        r_divEn;
    logic [3:0]  r_divVal;
    logic [31:0] r_tdr;
    logic [31:0] r_cnt;
    logic [1:0]  r_tier;
    logic [1:0]  r_tisr;
    logic [7:0]  r_divCnt;

    logic [9:0]  w_idx;
    logic        w_wr;
    logic        w_wrTcr;
    logic        w_wrTdr;
    logic        w_wrTier;
    logic        w_wrTisr;
    logic        w_load;
    logic        w_divChange;
    logic [3:0]  w_d;
    logic [7:0]  w_divTop;
    logic        w_divWrap;
    logic        w_tick;
    logic        w_ovf;
    logic        w_udf;
    logic [1:0]  w_w1c;
    logic        w_unused;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;
    assign w_unused    = &{1'b0, apb.paddr[1:0]};

    assign w_idx    = apb.paddr[11:2];
    assign w_wr     = apb.psel & apb.penable & apb.pwrite;
    assign w_wrTcr  = w_wr & (w_idx == A_TCR);
    assign w_wrTdr  = w_wr & (w_idx == A_TDR);
    assign w_wrTier = w_wr & (w_idx == A_TIER);
    assign w_wrTisr = w_wr & (w_idx == A_TISR);
    assign w_load   = w_wrTcr & apb.pwdata[2];
    assign w_w1c    = w_wrTisr ? apb.pwdata[1:0] : 2'b00;

    assign w_divChange = w_wrTcr & ((apb.pwdata[3] != r_divEn) || (apb.pwdata[11:8] != r_divVal));

    // Divider exponent saturates at 8; 1<<8 overflows the 8-bit shift to 0, so top becomes 0xFF.
    assign w_d       = (r_divVal > 4'd8) ? 4'd8 : r_divVal;
    assign w_divTop  = (8'd1 << w_d) - 8'd1;
    assign w_divWrap = (r_divCnt == w_divTop);
    assign w_tick    = r_en & (r_divEn ? w_divWrap : 1'b1);

    assign w_ovf = w_tick & ~r_updown & (r_cnt == 32'hFFFF_FFFF) & ~w_load;
    assign w_udf = w_tick &  r_updown & (r_cnt == 32'h0000_0000) & ~w_load;

    assign o_tmr_irq = |(r_tisr & r_tier);

    always_ff @(posedge i_pclk) begin
        if (!i_preset_n) begin
            r_en     <= 1'b0;
            r_updown <= 1'b0;
            r_divEn  <= 1'b0;
            r_divVal <= 4'd0;
            r_tdr    <= 32'd0;
            r_cnt    <= 32'd0;
            r_tier   <= 2'b00;
            r_tisr   <= 2'b00;
            r_divCnt <= 8'd0;
        end else begin
            if (w_wrTcr) begin
                r_en     <= apb.pwdata[0];
                r_updown <= apb.pwdata[1];
                r_divEn  <= apb.pwdata[3];
                r_divVal <= apb.pwdata[11:8];
            end
            if (w_wrTdr) begin
                r_tdr <= apb.pwdata;
            end
            if (w_wrTier) begin
                r_tier <= apb.pwdata[1:0];
            end

            // A new event wins over a same-edge write-1-to-clear of its bit.
            r_tisr <= (r_tisr & ~w_w1c) | {w_udf, w_ovf};

            if (w_load) begin
                r_cnt <= r_tdr;
            end else if (w_tick) begin
                r_cnt <= r_updown ? (r_cnt - 32'd1) : (r_cnt + 32'd1);
            end

            if (!r_en || !r_divEn || w_divChange || w_divWrap) begin
                r_divCnt <= 8'd0;
            end else begin
                r_divCnt <= r_divCnt + 8'd1;
            end
        end
    end

    always_comb begin
        apb.prdata = 32'd0;
        if (apb.psel && !apb.pwrite) begin
            case (w_idx)
                A_TCR:   apb.prdata = {20'd0, r_divVal, 4'd0, r_divEn, 1'b0, r_updown, r_en};
                A_TDR:   apb.prdata = r_tdr;
                A_TCNT:  apb.prdata = r_cnt;
                A_TIER:  apb.prdata = {30'd0, r_tier};
                A_TISR:  apb.prdata = {30'd0, r_tisr};
                default: apb.prdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations, then random
// APB traffic checked against a cycle-level arithmetic model of the timer.
module tb_timer_ctrl;
    logic pclk     = 1'b0;
    logic preset_n = 1'b0;
    logic tmrIrq;
    int   checks   = 0;
    int   errors   = 0;
    bit   monOn    = 1'b0;

    timer_ctrl_if apb ();

    timer_ctrl dut (
        .i_pclk     (pclk),
        .i_preset_n (preset_n),
        .apb        (apb),
        .o_tmr_irq  (tmrIrq)
    );

    always #5 pclk = ~pclk;

    bit        mEn;
    bit        mDown;
    bit        mDivEn;
    bit [3:0]  mDivVal;
    bit [31:0] mTdr;
    bit [31:0] mCnt;
    bit [1:0]  mTier;
    bit [1:0]  mTisr;
    int        mPhase;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expRead(input logic [11:0] addr);
        case (addr[11:2])
            10'd0:   return {20'd0, mDivVal, 4'd0, mDivEn, 1'b0, mDown, mEn};
            10'd1:   return mTdr;
            10'd2:   return mCnt;
            10'd3:   return {30'd0, mTier};
            10'd4:   return {30'd0, mTisr};
            default: return 32'd0;
        endcase
    endfunction

    // Model: counter moves by +/-1 once per prescaler period; a wrap is seen as the 33rd bit.
    always @(posedge pclk) begin : refModel
        bit        wr;
        bit        tick;
        bit        load;
        bit        divChange;
        int        idx;
        int        period;
        int        dEff;
        bit [32:0] wide;
        bit [31:0] newCnt;
        bit [1:0]  ev;
        bit [1:0]  w1c;
        if (!preset_n) begin
            mEn = 0; mDown = 0; mDivEn = 0; mDivVal = 0;
            mTdr = 0; mCnt = 0; mTier = 0; mTisr = 0; mPhase = 0;
        end else begin
            wr     = apb.psel && apb.penable && apb.pwrite;
            idx    = int'(apb.paddr[11:2]);
            dEff   = (mDivVal > 4'd8) ? 8 : int'(mDivVal);
            period = mDivEn ? (1 << dEff) : 1;
            tick   = mEn && (mPhase == period - 1);
            load   = wr && (idx == 0) && apb.pwdata[2];
            ev     = 2'b00;
            newCnt = mCnt;
            if (load) begin
                newCnt = mTdr;
            end else if (tick) begin
                if (!mDown) begin
                    wide   = {1'b0, mCnt} + 33'd1;
                    ev[0]  = wide[32];
                end else begin
                    wide   = {1'b0, mCnt} - 33'd1;
                    ev[1]  = wide[32];
                end
                newCnt = wide[31:0];
            end
            divChange = wr && (idx == 0) && ((apb.pwdata[3] != mDivEn) || (apb.pwdata[11:8] != mDivVal));
            mPhase = (mEn && mDivEn && !divChange) ? ((mPhase + 1) % period) : 0;
            w1c    = (wr && idx == 4) ? apb.pwdata[1:0] : 2'b00;
            mTisr  = (mTisr & ~w1c) | ev;
            mCnt   = newCnt;
            if (wr) begin
                case (idx)
                    0: begin
                        mEn = apb.pwdata[0]; mDown = apb.pwdata[1];
                        mDivEn = apb.pwdata[3]; mDivVal = apb.pwdata[11:8];
                    end
                    1: mTdr  = apb.pwdata;
                    3: mTier = apb.pwdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge pclk) begin
        if (monOn) begin
            #2;
            checkOutput("irq", {31'd0, tmrIrq}, {31'd0, |(mTier & mTisr)});
            if (!apb.psel) checkOutput("prdata_idle", apb.prdata, 32'd0);
        end
    end

    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = addr; apb.pwdata = data;
        @(negedge pclk);
        apb.penable = 1'b1;
        @(negedge pclk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic readReg(input logic [11:0] addr, input string tag, output logic [31:0] value);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
        @(negedge pclk);
        apb.penable = 1'b1;
        #1;
        value = apb.prdata;
        checkOutput(tag, value, expRead(addr));
        @(negedge pclk);
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    // Holds a read select open and samples TCNT and TISR in the same cycle.
    task automatic peekCount(input string tag, input logic [31:0] cntExp, input logic [1:0] tisrExp);
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0;
        apb.paddr = 12'h008;
        #1 checkOutput({tag, "_tcnt"}, apb.prdata, cntExp);
        apb.paddr = 12'h010;
        #1 checkOutput({tag, "_tisr"}, apb.prdata, {30'd0, tisrExp});
        @(negedge pclk);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] data;
        logic [31:0] upSeq [4];
        logic [11:0] lo;
        logic [11:0] a;
        int          op;

        upSeq = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = 12'h000; apb.pwdata = 32'd0;
        repeat (3) @(negedge pclk);
        preset_n = 1'b1;
        monOn    = 1'b1;

        checkOutput("pready", {31'd0, apb.pready}, 32'd1);
        checkOutput("pslverr", {31'd0, apb.pslverr}, 32'd0);
        for (int i = 0; i <= 4; i++) begin
            readReg(12'(i * 4), "reset_read", v);
            checkOutput("reset_zero", v, 32'd0);
        end

        applyStimulus(12'h004, 32'hFFFF_FFFD);
        applyStimulus(12'h000, 32'h0000_0005);
        for (int k = 0; k < 4; k++) peekCount("ovf", upSeq[k], (k == 3) ? 2'b01 : 2'b00);
        apb.psel = 1'b0;
        applyStimulus(12'h00C, 32'h1);
        #1 checkOutput("irq_ovf_on", {31'd0, tmrIrq}, 32'd1);
        applyStimulus(12'h010, 32'h1);
        #1 checkOutput("irq_ovf_cleared", {31'd0, tmrIrq}, 32'd0);
        applyStimulus(12'h000, 32'h0);

        applyStimulus(12'h004, 32'hFFFF_FFFD);
        applyStimulus(12'h000, 32'h0000_0005);
        @(negedge pclk);
        applyStimulus(12'h010, 32'h1);
        readReg(12'h010, "collide_read", v);
        checkOutput("collide_set_wins", v, 32'h1);
        applyStimulus(12'h000, 32'h0);

        applyStimulus(12'h004, 32'h2);
        applyStimulus(12'h000, 32'h0000_020F);
        for (int k = 0; k <= 12; k++) begin
            peekCount("udf", (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : (k < 12) ? 32'd0 : 32'hFFFF_FFFF,
                      (k < 12) ? 2'b01 : 2'b11);
        end
        apb.psel = 1'b0;

        preset_n = 1'b0;
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        checkOutput("midreset_irq", {31'd0, tmrIrq}, 32'd0);
        for (int i = 0; i <= 4; i++) begin
            readReg(12'(i * 4), "midreset_read", v);
            checkOutput("midreset_zero", v, 32'd0);
        end
        repeat (5) @(negedge pclk);
        readReg(12'h008, "idle_tcnt", v);
        checkOutput("idle_tcnt_zero", v, 32'd0);

        applyStimulus(12'h004, 32'hFFFF_FFFF);
        applyStimulus(12'h000, 32'h0000_020D);
        applyStimulus(12'h004, 32'h0);
        applyStimulus(12'h000, 32'h0000_020D);
        readReg(12'h008, "loadsup_read", v);
        checkOutput("loadsup_tcnt", v, 32'd0);
        readReg(12'h010, "loadsup_tisr_read", v);
        checkOutput("loadsup_tisr", v, 32'd0);
        applyStimulus(12'h000, 32'h0);

        readReg(12'h020, "illegal_read", v);
        checkOutput("illegal_zero", v, 32'd0);
        applyStimulus(12'h004, 32'h1234);
        applyStimulus(12'h000, 32'h4);
        applyStimulus(12'h008, 32'h5);
        readReg(12'h008, "tcnt_ro_read", v);
        checkOutput("tcnt_ro", v, 32'h1234);

        applyStimulus(12'h004, 32'h0);
        applyStimulus(12'h000, 32'h0000_0F0D);
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = 12'h008;
        repeat (255) @(negedge pclk);
        #1 checkOutput("div15_before", apb.prdata, 32'd0);
        @(negedge pclk);
        #1 checkOutput("div15_tick", apb.prdata, 32'd1);
        apb.psel = 1'b0;
        applyStimulus(12'h000, 32'h0);
        readReg(12'h008, "hold_read", v);
        checkOutput("hold_tcnt", v, 32'd1);
        repeat (300) @(negedge pclk);
        readReg(12'h008, "hold_read2", v);
        checkOutput("hold_tcnt_later", v, 32'd1);

        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            lo = 12'($urandom_range(0, 3));
            case (op)
                0, 1: begin
                    data       = $urandom & 32'hFFFF_F0F0;
                    data[0]    = ($urandom_range(0, 3) != 0);
                    data[1]    = 1'($urandom_range(0, 1));
                    data[2]    = ($urandom_range(0, 2) == 0);
                    data[3]    = 1'($urandom_range(0, 1));
                    data[11:8] = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
                    applyStimulus(12'h000 | lo, data);
                end
                2: begin
                    case ($urandom_range(0, 6))
                        0: data = 32'h0;
                        1: data = 32'h1;
                        2: data = 32'h2;
                        3: data = 32'hFFFF_FFFD;
                        4: data = 32'hFFFF_FFFE;
                        5: data = 32'hFFFF_FFFF;
                        default: data = $urandom;
                    endcase
                    applyStimulus(12'h004 | lo, data);
                end
                3: applyStimulus(12'h00C | lo, $urandom);
                4: applyStimulus(12'h010 | lo, $urandom);
                5: applyStimulus(12'h008 | lo, $urandom);
                6: applyStimulus(12'($urandom_range(5, 1023) * 4) | lo, $urandom);
                7, 8: begin
                    a = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 1023) * 4)
                                                    : 12'($urandom_range(0, 5) * 4);
                    readReg(a | lo, "rand_read", v);
                end
                default: repeat ($urandom_range(1, 30)) @(negedge pclk);
            endcase
        end

        monOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
